// File: rtl/gray_counter_updn.sv
// gray_counter_updn
//   Parametrised up/down Gray-code counter with synchronous load and a
//   programmable modulus. All arithmetic is done on a binary index. The Gray
//   code is computed from the next index and registered in its own flops, so
//   the out bus has no decode glitches.
//
//   Cascading: connect tc of one stage to cten of the next stage. tc is high
//   during the cycle whose clock edge wraps this stage. The next stage
//   therefore steps on the same edge, and no ripple delay builds up.
//
// Parameters
//   WIDTH     counter width in bits (>= 2)
//   MODULO    count length, 2 .. 2**WIDTH; the index runs 0 .. MODULO-1
//
// Ports
//   clk       rising-edge clock
//   clr       asynchronous active-low reset of all state
//   cten      count enable, one step per edge while high
//   up_dn     direction: 1 = up, 0 = down
//   load      synchronous load strobe; has priority over cten
//   load_val  binary index to load; values >= MODULO saturate to MODULO-1
//   ovf_clr   synchronous clear of the sticky ovf flag
//   out       registered Gray code of the index
//   bin       registered binary index
//   tc        terminal count (combinational), used for cascading
//   ovf       sticky wrap flag (registered)
module gray_counter_updn #(
  parameter int WIDTH  = 4,
  parameter int MODULO = 2**WIDTH
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             cten,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] bin,
  output logic             tc,
  output logic             ovf
);

  // MODULO may be 2**WIDTH, which does not fit in WIDTH bits. The load
  // range check is therefore done one bit wider.
  localparam logic [WIDTH-1:0] LAST    = WIDTH'(MODULO - 1);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULO);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  logic [WIDTH-1:0] idx;
  logic [WIDTH-1:0] idx_nxt;
  logic             at_last;
  logic             at_zero;
  logic             wrap;

  function automatic logic [WIDTH-1:0] to_gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  assign at_last = (idx == LAST);
  assign at_zero = (idx == '0);

  assign tc  = cten & ~load & ((up_dn & at_last) | (~up_dn & at_zero));
  assign bin = idx;

  always_comb begin
    idx_nxt = idx;
    wrap    = 1'b0;
    if (load) begin
      idx_nxt = ({1'b0, load_val} >= MOD_EXT) ? LAST : load_val;
    end else if (cten) begin
      if (up_dn) begin
        if (at_last) begin
          idx_nxt = '0;
          wrap    = 1'b1;
        end else begin
          idx_nxt = idx + ONE;
        end
      end else begin
        if (at_zero) begin
          idx_nxt = LAST;
          wrap    = 1'b1;
        end else begin
          idx_nxt = idx - ONE;
        end
      end
    end
  end

  // out is registered from idx_nxt, so it is aligned with bin with no extra
  // latency. A wrap sets ovf even when ovf_clr is asserted on the same edge.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      idx <= '0;
      out <= '0;
      ovf <= 1'b0;
    end else begin
      idx <= idx_nxt;
      out <= to_gray(idx_nxt);
      ovf <= wrap | (ovf & ~ovf_clr);
    end
  end

endmodule

// File: tb/tb_gray_counter_updn.sv
module tb_gray_counter_updn;

  logic clk;
  int   checks;
  int   failures;

  // DUT A: WIDTH=4, MODULO=16
  logic       a_clr, a_cten, a_up, a_load, a_oc;
  logic [3:0] a_lv, a_out, a_bin;
  logic       a_tc, a_ovf;
  // DUT B: WIDTH=4, MODULO=10
  logic       b_clr, b_cten, b_up, b_load, b_oc;
  logic [3:0] b_lv, b_out, b_bin;
  logic       b_tc, b_ovf;
  // Cascade C0 -> C1
  logic       c_clr, c0_cten, c_up, c_load, c_oc;
  logic [3:0] c_lv, c0_out, c0_bin, c1_out, c1_bin;
  logic       c0_tc, c0_ovf, c1_tc, c1_ovf;

  gray_counter_updn #(.WIDTH(4), .MODULO(16)) u_a (
    .clk(clk), .clr(a_clr), .cten(a_cten), .up_dn(a_up), .load(a_load),
    .load_val(a_lv), .ovf_clr(a_oc), .out(a_out), .bin(a_bin), .tc(a_tc), .ovf(a_ovf));

  gray_counter_updn #(.WIDTH(4), .MODULO(10)) u_b (
    .clk(clk), .clr(b_clr), .cten(b_cten), .up_dn(b_up), .load(b_load),
    .load_val(b_lv), .ovf_clr(b_oc), .out(b_out), .bin(b_bin), .tc(b_tc), .ovf(b_ovf));

  gray_counter_updn #(.WIDTH(4), .MODULO(16)) u_c0 (
    .clk(clk), .clr(c_clr), .cten(c0_cten), .up_dn(c_up), .load(c_load),
    .load_val(c_lv), .ovf_clr(c_oc), .out(c0_out), .bin(c0_bin), .tc(c0_tc), .ovf(c0_ovf));

  gray_counter_updn #(.WIDTH(4), .MODULO(16)) u_c1 (
    .clk(clk), .clr(c_clr), .cten(c0_tc), .up_dn(c_up), .load(c_load),
    .load_val(c_lv), .ovf_clr(c_oc), .out(c1_out), .bin(c1_bin), .tc(c1_tc), .ovf(c1_ovf));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit cten; bit up; bit load; int lv; bit oc;
    bit etc; int ebin; int eout; bit eovf;
  } vec_t;

  vec_t tab[$];
  int   gtab[16];
  int   up_out[16] = '{1, 3, 2, 6, 7, 5, 4, 'hC, 'hD, 'hF, 'hE, 'hA, 'hB, 9, 8, 0};

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Reference model: index arithmetic straight from the counting rules
  task automatic m_step(inout int idx, inout bit ov, input int modv, input bit ld,
                        input int lv, input bit ct, input bit ud, input bit oc);
    bit wr;
    wr = 1'b0;
    if (ld) idx = (lv >= modv) ? modv - 1 : lv;
    else if (ct) begin
      if (ud) begin
        wr = (idx == modv - 1);
        idx = (idx + 1) % modv;
      end else begin
        wr = (idx == 0);
        idx = (idx + modv - 1) % modv;
      end
    end
    if (wr) ov = 1'b1;
    else if (oc) ov = 1'b0;
  endtask

  function automatic bit m_tc(input int idx, input int modv, input bit ld,
                              input bit ct, input bit ud);
    if (ld || !ct) return 1'b0;
    return ud ? (idx == modv - 1) : (idx == 0);
  endfunction

  int  ma_idx, mb_idx;
  bit  ma_ovf, mb_ovf;
  logic [3:0] prev_out;

  initial begin
    checks = 0;
    failures = 0;

    // Reflected Gray sequence built by mirroring
    begin
      int n;
      gtab[0] = 0;
      n = 1;
      for (int b = 0; b < 4; b++) begin
        for (int i = 0; i < n; i++) gtab[2*n-1-i] = gtab[i] | (1 << b);
        n = n * 2;
      end
    end

    // Test 1 (up count from reset), then test 2 (down count), then test 6
    for (int i = 0; i < 16; i++)
      tab.push_back('{1, 1, 0, 0, 0, (i == 15), (i + 1) % 16, up_out[i], (i == 15)});
    tab.push_back('{0, 1, 0, 0, 1, 0, 0,  0,   0});
    tab.push_back('{1, 0, 0, 0, 0, 1, 15, 8,   1});
    tab.push_back('{1, 0, 0, 0, 0, 0, 14, 9,   1});
    tab.push_back('{1, 1, 1, 15, 0, 0, 15, 8,  1});
    tab.push_back('{1, 1, 0, 0, 1, 1, 0,  0,   1});
    tab.push_back('{0, 1, 0, 0, 1, 0, 0,  0,   0});
    tab.push_back('{1, 1, 0, 0, 1, 0, 1,  1,   0});

    {a_clr, a_cten, a_up, a_load, a_oc, a_lv} = '0;
    {b_clr, b_cten, b_up, b_load, b_oc, b_lv} = '0;
    {c_clr, c0_cten, c_load, c_oc, c_lv} = '0;
    c_up = 1'b1;

    // Reset state and tc while in reset
    a_cten = 1'b1; a_up = 1'b0;
    #1;
    chk("rst_tc_down", int'(a_tc), 1);
    chk("rst_bin", int'(a_bin), 0);
    chk("rst_out", int'(a_out), 0);
    chk("rst_ovf", int'(a_ovf), 0);
    a_up = 1'b1;
    #1;
    chk("rst_tc_up", int'(a_tc), 0);
    @(posedge clk); #1;
    chk("rst_hold_bin", int'(a_bin), 0);
    a_cten = 1'b0;
    a_clr = 1'b1; b_clr = 1'b1; c_clr = 1'b1;
    @(posedge clk); #1;
    chk("idle_bin", int'(a_bin), 0);

    foreach (tab[i]) begin
      a_cten = tab[i].cten; a_up = tab[i].up; a_load = tab[i].load;
      a_lv = 4'(tab[i].lv); a_oc = tab[i].oc;
      #1;
      chk($sformatf("vec%0d_tc", i), int'(a_tc), int'(tab[i].etc));
      @(posedge clk); #1;
      chk($sformatf("vec%0d_bin", i), int'(a_bin), tab[i].ebin);
      chk($sformatf("vec%0d_out", i), int'(a_out), tab[i].eout);
      chk($sformatf("vec%0d_ovf", i), int'(a_ovf), int'(tab[i].eovf));
    end
    {a_cten, a_load, a_oc} = '0;

    // Test 5: asynchronous reset between edges at bin=7
    a_clr = 1'b0; #1; a_clr = 1'b1;
    a_cten = 1'b1; a_up = 1'b1;
    repeat (7) @(posedge clk);
    #1;
    chk("t5_pre_bin", int'(a_bin), 7);
    #3;
    a_clr = 1'b0; a_load = 1'b1; a_lv = 4'd5;
    #1;
    chk("t5_async_bin", int'(a_bin), 0);
    chk("t5_async_out", int'(a_out), 0);
    @(posedge clk); #1;
    chk("t5_load_discard", int'(a_bin), 0);
    a_clr = 1'b1; a_load = 1'b0;
    @(posedge clk); #1;
    chk("t5_first_bin", int'(a_bin), 1);
    chk("t5_first_out", int'(a_out), 1);
    a_cten = 1'b0;

    // Test 3: MODULO=10
    b_cten = 1'b1; b_up = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk($sformatf("t3_tc%0d", i), int'(b_tc), int'(i == 9));
      @(posedge clk); #1;
      chk($sformatf("t3_bin%0d", i), int'(b_bin), (i + 1) % 10);
      chk($sformatf("t3_ovf%0d", i), int'(b_ovf), int'(i == 9));
    end
    b_cten = 1'b0; b_oc = 1'b1;
    @(posedge clk); #1;
    chk("t3_ovf_clr", int'(b_ovf), 0);
    b_oc = 1'b0; b_load = 1'b1; b_lv = 4'd12; b_cten = 1'b1;
    #1;
    chk("t3_load_tc", int'(b_tc), 0);
    @(posedge clk); #1;
    chk("t3_load_sat_bin", int'(b_bin), 9);
    chk("t3_load_sat_out", int'(b_out), 'hD);
    chk("t3_load_no_ovf", int'(b_ovf), 0);
    b_load = 1'b0;
    #1;
    chk("t3_tc_after_load", int'(b_tc), 1);
    @(posedge clk); #1;
    chk("t3_wrap_bin", int'(b_bin), 0);
    chk("t3_wrap_ovf", int'(b_ovf), 1);
    b_cten = 1'b0;

    // Test 4: cascade
    c0_cten = 1'b1;
    for (int k = 1; k <= 256; k++) begin
      @(posedge clk); #1;
      chk($sformatf("t4_c0_bin%0d", k), int'(c0_bin), k % 16);
      chk($sformatf("t4_c1_bin%0d", k), int'(c1_bin), (k / 16) % 16);
      chk($sformatf("t4_c1_ovf%0d", k), int'(c1_ovf), int'(k == 256));
    end
    chk("t4_c1_out", int'(c1_out), 0);
    c0_cten = 1'b0;

    // Randomised run against the reference model
    a_clr = 1'b0; b_clr = 1'b0; #1;
    ma_idx = 0; ma_ovf = 0; mb_idx = 0; mb_ovf = 0;
    for (int k = 0; k < 600; k++) begin
      a_clr  = ($urandom_range(0, 49) != 0);
      a_load = ($urandom_range(0, 7) == 0);
      a_lv   = 4'($urandom_range(0, 15));
      a_cten = ($urandom_range(0, 3) != 0);
      a_up   = 1'($urandom_range(0, 1));
      a_oc   = ($urandom_range(0, 7) == 0);
      b_clr  = ($urandom_range(0, 49) != 0);
      b_load = ($urandom_range(0, 7) == 0);
      b_lv   = 4'($urandom_range(0, 15));
      b_cten = ($urandom_range(0, 3) != 0);
      b_up   = 1'($urandom_range(0, 1));
      b_oc   = ($urandom_range(0, 7) == 0);
      if (!a_clr) begin ma_idx = 0; ma_ovf = 0; end
      if (!b_clr) begin mb_idx = 0; mb_ovf = 0; end
      #1;
      chk("rnd_a_tc", int'(a_tc), int'(m_tc(ma_idx, 16, a_load, a_cten, a_up)));
      chk("rnd_b_tc", int'(b_tc), int'(m_tc(mb_idx, 10, b_load, b_cten, b_up)));
      prev_out = a_out;
      @(posedge clk);
      if (a_clr) m_step(ma_idx, ma_ovf, 16, a_load, int'(a_lv), a_cten, a_up, a_oc);
      if (b_clr) m_step(mb_idx, mb_ovf, 10, b_load, int'(b_lv), b_cten, b_up, b_oc);
      #1;
      chk("rnd_a_bin", int'(a_bin), ma_idx);
      chk("rnd_a_out", int'(a_out), gtab[ma_idx]);
      chk("rnd_a_ovf", int'(a_ovf), int'(ma_ovf));
      chk("rnd_b_bin", int'(b_bin), mb_idx);
      chk("rnd_b_out", int'(b_out), gtab[mb_idx]);
      chk("rnd_b_ovf", int'(b_ovf), int'(mb_ovf));
      if (a_clr && !a_load)
        chk("rnd_a_gray_1bit", int'($countones(a_out ^ prev_out) <= 1), 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
